// File: rtl/seq_hex_calculator_pkg.sv
// Shared types and constants for the sequential hex calculator.
// Op 3 is MUL when CALC_MUL_EN is defined, otherwise OR.
package calc_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
`ifdef CALC_MUL_EN
    OP_MUL = 2'd3
`else
    OP_OR  = 2'd3
`endif
  } op_e;

  typedef enum logic [1:0] {
    S_A   = 2'd0,
    S_B   = 2'd1,
    S_RES = 2'd2
  } state_e;

  localparam logic [6:0] SEG_ZERO = 7'h40;

  // Active-low segments, bit0=a .. bit6=g; entry 0 is the lowest slice.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seq_hex_calculator_seg7_hex_decoder.sv
// One hex nibble to active-low seven-segment pattern; purely combinational, no flow control.
module seg7_hex_decoder
  import calc_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_LUT[nibble];

endmodule

// File: rtl/seq_hex_calculator.sv
// Sequential A/op/B calculator with chaining and registered hex display (one cycle display lag).
// Buttons are synchronised (enter acts 3 edges after first sample); optional MUL via CALC_MUL_EN.
module seq_hex_calculator
  import calc_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int N_DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      operand_i,
  input  logic [1:0]            op_i,
  input  logic                  enter_i,
  input  logic                  clear_i,
  output logic [N_DIGITS*7-1:0] hex_o,
  output logic [1:0]            state_o,
  output logic                  overflow_o
);

`ifdef CALC_MUL_EN
  localparam int RES_W = 2 * WIDTH;
`else
  localparam int RES_W = WIDTH + 1;
`endif
  localparam int DISP_W = N_DIGITS * 4;

  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("seq_hex_calculator: WIDTH must be in 2..16");
  end
  if (DISP_W < RES_W) begin : g_bad_digits
    $error("seq_hex_calculator: N_DIGITS too small to show the full result");
  end

  logic enter_s1, enter_s2, enter_prev;
  logic clear_s1, clear_s2;
  logic enter_edge;

  state_e             state;
  logic [WIDTH-1:0]   reg_a;
  logic [RES_W-1:0]   result;
  logic               overflow;
  logic [N_DIGITS*7-1:0] hex_q;

  op_e                op_sel;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   diff;
  logic [RES_W-1:0]   alu_res;
  logic               alu_ovf;
  logic [DISP_W-1:0]  disp;
  logic [N_DIGITS*7-1:0] seg_comb;

  assign enter_edge = enter_s2 & ~enter_prev;

  // Operand B never needs storing: it is folded into the result on the capture edge.
  assign op_sel = op_e'(op_i);
  assign sum    = {1'b0, reg_a} + {1'b0, operand_i};
  assign diff   = reg_a - operand_i;

`ifdef CALC_MUL_EN
  logic [2*WIDTH-1:0] prod;
  assign prod = reg_a * operand_i;
`endif

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op_sel)
      OP_ADD: begin
        alu_res = RES_W'(sum);
        alu_ovf = sum[WIDTH];
      end
      OP_SUB: begin
        alu_res = RES_W'(diff);
        alu_ovf = (reg_a < operand_i);
      end
      OP_AND: alu_res = RES_W'(reg_a & operand_i);
`ifdef CALC_MUL_EN
      OP_MUL: begin
        alu_res = prod;
        alu_ovf = |prod[2*WIDTH-1:WIDTH];
      end
`else
      OP_OR:  alu_res = RES_W'(reg_a | operand_i);
`endif
      default: ;
    endcase
  end

  always_comb begin
    disp = '0;
    if (state == S_RES) disp = DISP_W'(result);
    else                disp = DISP_W'(operand_i);
  end

  for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit
    seg7_hex_decoder u_dec (
      .nibble (disp[4*k +: 4]),
      .seg    (seg_comb[7*k +: 7])
    );
  end

  // Enter sync flops reset high so a button held through reset never looks like a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      enter_s1   <= 1'b1;
      enter_s2   <= 1'b1;
      enter_prev <= 1'b1;
      clear_s1   <= 1'b0;
      clear_s2   <= 1'b0;
    end else begin
      enter_s1   <= enter_i;
      enter_s2   <= enter_s1;
      enter_prev <= enter_s2;
      clear_s1   <= clear_i;
      clear_s2   <= clear_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_A;
      reg_a    <= '0;
      result   <= '0;
      overflow <= 1'b0;
      hex_q    <= {N_DIGITS{SEG_ZERO}};
    end else begin
      hex_q <= seg_comb;
      if (clear_s2) begin
        state    <= S_A;
        reg_a    <= '0;
        result   <= '0;
        overflow <= 1'b0;
      end else begin
        case (state)
          S_A: if (enter_edge) begin
            reg_a <= operand_i;
            state <= S_B;
          end
          S_B: if (enter_edge) begin
            result   <= alu_res;
            overflow <= alu_ovf;
            state    <= S_RES;
          end
          S_RES: if (enter_edge) begin
            reg_a <= result[WIDTH-1:0];
            state <= S_B;
          end
          default: state <= S_A;
        endcase
      end
    end
  end

  assign hex_o      = hex_q;
  assign state_o    = state;
  assign overflow_o = overflow;

endmodule

// File: tb/tb_seq_hex_calculator.sv
// Directed vector table plus hand sequences for reset, chaining, hold and clear priority.
module tb_seq_hex_calculator;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  operand_i;
  logic [1:0]  op_i;
  logic        enter_i;
  logic        clear_i;
  logic [27:0] hex_o;
  logic [1:0]  state_o;
  logic        overflow_o;

  int checks   = 0;
  int failures = 0;

  logic [6:0] seg_tbl [16];

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [1:0]  op;
    logic [15:0] disp;
    logic        ovf;
  } vec_t;

  vec_t vecs [10];

  seq_hex_calculator #(.WIDTH(8), .N_DIGITS(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .operand_i  (operand_i),
    .op_i       (op_i),
    .enter_i    (enter_i),
    .clear_i    (clear_i),
    .hex_o      (hex_o),
    .state_o    (state_o),
    .overflow_o (overflow_o)
  );

  always #5 clk = ~clk;

  function automatic logic [27:0] exp_hex(input logic [15:0] v);
    logic [27:0] h;
    h = '0;
    for (int k = 0; k < 4; k++) h[7*k +: 7] = seg_tbl[v[4*k +: 4]];
    return h;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int hold);
    enter_i = 1'b1;
    cyc(hold);
    enter_i = 1'b0;
    cyc(4);
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    cyc(4);
    clear_i = 1'b0;
    cyc(4);
  endtask

  task automatic run_vec(input int i);
    do_clear();
    check($sformatf("v%0d_state_after_clear", i), 32'(state_o), 32'd0);
    operand_i = vecs[i].a;
    press(4);
    check($sformatf("v%0d_state_b", i), 32'(state_o), 32'd1);
    op_i      = vecs[i].op;
    operand_i = vecs[i].b;
    press(4);
    check($sformatf("v%0d_state_res", i), 32'(state_o), 32'd2);
    check($sformatf("v%0d_hex", i), 32'(hex_o), 32'(exp_hex(vecs[i].disp)));
    check($sformatf("v%0d_ovf", i), 32'(overflow_o), 32'(vecs[i].ovf));
  endtask

  initial begin
    seg_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    vecs[0] = '{8'hC8, 8'h64, 2'd0, 16'h012C, 1'b1};
    vecs[1] = '{8'h05, 8'h07, 2'd1, 16'h00FE, 1'b1};
    vecs[2] = '{8'h07, 8'h05, 2'd1, 16'h0002, 1'b0};
    vecs[3] = '{8'hFF, 8'h01, 2'd0, 16'h0100, 1'b1};
    vecs[4] = '{8'h10, 8'h20, 2'd0, 16'h0030, 1'b0};
    vecs[5] = '{8'hAA, 8'h0F, 2'd2, 16'h000A, 1'b0};
    vecs[6] = '{8'h00, 8'h00, 2'd1, 16'h0000, 1'b0};
    vecs[7] = '{8'h80, 8'h81, 2'd1, 16'h00FF, 1'b1};
`ifdef CALC_MUL_EN
    vecs[8] = '{8'hFF, 8'hFF, 2'd3, 16'hFE01, 1'b1};
    vecs[9] = '{8'hA0, 8'h05, 2'd3, 16'h0320, 1'b1};
`else
    vecs[8] = '{8'hFF, 8'hFF, 2'd3, 16'h00FF, 1'b0};
    vecs[9] = '{8'hA0, 8'h05, 2'd3, 16'h00A5, 1'b0};
`endif

    // Reset with enter held across release.
    reset     = 1'b1;
    operand_i = 8'h00;
    op_i      = 2'd0;
    enter_i   = 1'b1;
    clear_i   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_hex", 32'(hex_o), 32'h0810_2040);
    check("reset_state", 32'(state_o), 32'd0);
    check("reset_ovf", 32'(overflow_o), 32'd0);
    cyc(10);
    check("held_enter_no_edge", 32'(state_o), 32'd0);
    check("held_enter_hex", 32'(hex_o), 32'(exp_hex(16'h0000)));
    enter_i = 1'b0;
    cyc(4);

    operand_i = 8'h3B;
    cyc(3);
    check("live_operand_sa", 32'(hex_o), 32'(exp_hex(16'h003B)));

    for (int i = 0; i < 10; i++) run_vec(i);

    // Chaining from 0x12C, operand changes after capture, and a long hold.
    run_vec(0);
    operand_i = 8'h77;
    op_i      = 2'd1;
    cyc(4);
    check("res_ignores_inputs_hex", 32'(hex_o), 32'(exp_hex(16'h012C)));
    press(4);
    check("chain_state_b", 32'(state_o), 32'd1);
    check("chain_live_hex", 32'(hex_o), 32'(exp_hex(16'h0077)));
    op_i      = 2'd2;
    operand_i = 8'h0F;
    press(4);
    check("chain_and_state", 32'(state_o), 32'd2);
    check("chain_and_hex", 32'(hex_o), 32'(exp_hex(16'h000C)));
    check("chain_and_ovf", 32'(overflow_o), 32'd0);
    enter_i = 1'b1;
    cyc(50);
    check("hold50_one_transition", 32'(state_o), 32'd1);
    enter_i = 1'b0;
    cyc(4);
    check("hold50_after_release", 32'(state_o), 32'd1);
    op_i      = 2'd0;
    operand_i = 8'h01;
    press(4);
    check("chain2_hex", 32'(hex_o), 32'(exp_hex(16'h000D)));
    check("chain2_ovf", 32'(overflow_o), 32'd0);

    // Clear and enter rising together in S_B, with overflow previously set.
    run_vec(0);
    press(4);
    check("pre_clear_state_b", 32'(state_o), 32'd1);
    check("pre_clear_ovf", 32'(overflow_o), 32'd1);
    clear_i = 1'b1;
    enter_i = 1'b1;
    cyc(5);
    check("clear_beats_enter_state", 32'(state_o), 32'd0);
    check("clear_beats_enter_ovf", 32'(overflow_o), 32'd0);
    clear_i = 1'b0;
    enter_i = 1'b0;
    operand_i = 8'h5A;
    cyc(4);
    check("after_clear_state", 32'(state_o), 32'd0);
    check("after_clear_live_hex", 32'(hex_o), 32'(exp_hex(16'h005A)));

    // Reset from S_RES with overflow set.
    run_vec(3);
    operand_i = 8'h00;
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    check("midop_reset_state", 32'(state_o), 32'd0);
    check("midop_reset_ovf", 32'(overflow_o), 32'd0);
    check("midop_reset_hex", 32'(hex_o), 32'h0810_2040);
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
